// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing the data memory between CPU and loader
//
// Purpose: grants one of two req/ack requesters, latches its command, drives
// one memory access, waits out the read latency and returns a one-cycle ack.
//
// Ports:
//   clk, reset                   clock; asynchronous active-high reset
//   cpu_req/we/addr/wdata        CPU command, req held until cpu_ack
//   cpu_ack, cpu_rdata           CPU completion pulse and registered read data
//   ldr_req/we/addr/wdata        loader command, same protocol as the CPU
//   ldr_ack, ldr_rdata           loader completion pulse and read data
//   mem_en, mem_we               one-cycle memory strobe and write enable
//   mem_addr, mem_wdata          latched command fields
//   mem_rdata                    memory read data, RD_LAT cycles after mem_en
//   busy, owner                  not-IDLE flag; current owner (0 CPU, 1 loader)
module mem_port_arbiter #(
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  state_t     state, state_nxt;
  logic       we_q;
  logic [2:0] cnt;
  logic       last_grant;
  logic       grant_any;
  logic       grant_ldr;

  // On a tie the loader wins only if the CPU had the previous grant.
  always_comb begin
    grant_any = cpu_req | ldr_req;
    grant_ldr = ldr_req & (~cpu_req | ~last_grant);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    cpu_ack   = 1'b0;
    ldr_ack   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (grant_any) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        state_nxt = we_q ? DONE : WAIT;
      end
      WAIT: begin
        if (cnt == LAT) state_nxt = DONE;
      end
      DONE: begin
        cpu_ack   = ~owner;
        ldr_ack   = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q       <= 1'b0;
      cnt        <= 3'd0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            we_q       <= grant_ldr ? ldr_we    : cpu_we;
            mem_addr   <= grant_ldr ? ldr_addr  : cpu_addr;
            mem_wdata  <= grant_ldr ? ldr_wdata : cpu_wdata;
            owner      <= grant_ldr;
            last_grant <= grant_ldr;
          end
        end
        ISSUE: begin
          if (!we_q) cnt <= 3'd1;
        end
        WAIT: begin
          // cnt counts cycles since the strobe; data is valid when it reaches RD_LAT.
          if (cnt == LAT) begin
            if (owner) ldr_rdata <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
//
// Purpose: directed transactions push expected memory accesses and acks into
// queues; a negedge monitor pops and compares whenever the DUT strobes.
// Ports: none (top-level bench).
module tb_mem_port_arbiter;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req = 1'b0, ldr_we = 1'b0;
  logic [AW-1:0] ldr_addr = '0;
  logic [DW-1:0] ldr_wdata = '0;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy, owner;

  mem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears RD_LAT cycles after the strobe, junk otherwise.
  logic [DW-1:0] mem_model [0:255];
  logic [DW-1:0] rd_d [1:RD_LAT];
  logic          rd_v [1:RD_LAT];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= '0;
      mem_model[8'h20] <= 16'hBEEF;
      for (int i = 1; i <= RD_LAT; i++) begin
        rd_v[i] <= 1'b0;
        rd_d[i] <= '0;
      end
    end else begin
      if (mem_en && mem_we) mem_model[mem_addr[7:0]] <= mem_wdata;
      rd_v[1] <= mem_en && !mem_we;
      rd_d[1] <= mem_model[mem_addr[7:0]];
      for (int i = 2; i <= RD_LAT; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
    end
  end
  assign mem_rdata = rd_v[RD_LAT] ? rd_d[RD_LAT] : 16'hDEAD;

  typedef struct { int cyc; bit own; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { int cyc; bit rd; logic [DW-1:0] rdata; } ack_exp_t;
  mem_exp_t mem_q[$];
  ack_exp_t cpu_q[$];
  ack_exp_t ldr_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor
  logic [DW-1:0] cpu_sh = '0, ldr_sh = '0;
  bit after_ack = 1'b0;
  always @(negedge clk) begin
    mem_exp_t me;
    ack_exp_t ae;
    if (reset) begin
      cpu_sh    = '0;
      ldr_sh    = '0;
      after_ack = 1'b0;
    end else begin
      if (mem_we && !mem_en) chk("mem_we_without_en", 32'(mem_we), 0);
      if (after_ack) begin
        chk("busy_gap", 32'(busy), 0);
        chk("gap_mem_en", 32'(mem_en), 0);
      end
      after_ack = cpu_ack | ldr_ack;
      if (mem_en) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 32'(mem_en), 0);
        else begin
          me = mem_q.pop_front();
          chk("mem_cycle", 32'(cyc), 32'(me.cyc));
          chk("mem_owner", 32'(owner), 32'(me.own));
          chk("mem_we", 32'(mem_we), 32'(me.we));
          chk("mem_addr", 32'(mem_addr), 32'(me.addr));
          if (me.we) chk("mem_wdata", 32'(mem_wdata), 32'(me.wdata));
        end
      end
      if (cpu_ack) begin
        chk("cpu_ack_owner", 32'(owner), 0);
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'(cpu_ack), 0);
        else begin
          ae = cpu_q.pop_front();
          chk("cpu_ack_cycle", 32'(cyc), 32'(ae.cyc));
          if (ae.rd) begin
            chk("cpu_rdata", 32'(cpu_rdata), 32'(ae.rdata));
            cpu_sh = ae.rdata;
          end
          chk("ldr_rdata_hold", 32'(ldr_rdata), 32'(ldr_sh));
        end
      end
      if (ldr_ack) begin
        chk("ldr_ack_owner", 32'(owner), 1);
        if (ldr_q.size() == 0) chk("ldr_ack_unexpected", 32'(ldr_ack), 0);
        else begin
          ae = ldr_q.pop_front();
          chk("ldr_ack_cycle", 32'(cyc), 32'(ae.cyc));
          if (ae.rd) begin
            chk("ldr_rdata", 32'(ldr_rdata), 32'(ae.rdata));
            ldr_sh = ae.rdata;
          end
          chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(cpu_sh));
        end
      end
    end
  end

  task automatic drive(input bit port, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (port) begin ldr_we = we; ldr_addr = a; ldr_wdata = wd; ldr_req = 1'b1; end
    else      begin cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; end
  endtask

  task automatic push(input int c0, input bit port, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input bit want_ack);
    mem_exp_t me;
    ack_exp_t ae;
    me.cyc = c0 + 1; me.own = port; me.we = we; me.addr = a; me.wdata = wd;
    mem_q.push_back(me);
    if (want_ack) begin
      ae.cyc = we ? c0 + 2 : c0 + 2 + RD_LAT; ae.rd = !we; ae.rdata = rd;
      if (port) ldr_q.push_back(ae);
      else      cpu_q.push_back(ae);
    end
  endtask

  task automatic wait_ack(input bit port, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (port ? ldr_ack : cpu_ack) got = 1'b1;
    end
    chk(nm, 32'(got), 1);
  endtask

  task automatic run_txn(input bit port, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    @(negedge clk);
    drive(port, we, a, wd);
    push(cyc, port, we, a, wd, rd, 1'b1);
    wait_ack(port, "ack_seen");
    if (port) ldr_req = 1'b0;
    else      cpu_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {26'd0, mem_en, mem_we, cpu_ack, ldr_ack, busy, owner}, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", {cpu_rdata, ldr_rdata}, 0);
    reset = 1'b0;

    run_txn(0, 1, 16'h0010, 16'h1234, 16'h0000);
    run_txn(0, 0, 16'h0010, 16'h0000, 16'h1234);
    run_txn(1, 0, 16'h0020, 16'h0000, 16'hBEEF);
    run_txn(1, 1, 16'h0030, 16'h5A5A, 16'h0000);
    run_txn(1, 0, 16'h0030, 16'h0000, 16'h5A5A);

    // Command changed during ISSUE must not reach the memory.
    @(negedge clk);
    drive(0, 1, 16'h0005, 16'h1111);
    push(cyc, 0, 1, 16'h0005, 16'h1111, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    cpu_addr = 16'h0006; cpu_wdata = 16'h2222; cpu_we = 1'b0;
    wait_ack(0, "ack_seen_latch");
    cpu_req = 1'b0;
    run_txn(0, 0, 16'h0005, 16'h0000, 16'h1111);
    run_txn(0, 0, 16'h0006, 16'h0000, 16'h0000);

    // Req dropped right after grant: access and ack still happen exactly once.
    @(negedge clk);
    drive(0, 1, 16'h0040, 16'h7777);
    push(cyc, 0, 1, 16'h0040, 16'h7777, 16'h0000, 1'b1);
    @(negedge clk);
    cpu_req = 1'b0;
    wait_ack(0, "ack_seen_drop");
    repeat (6) @(negedge clk);
    run_txn(0, 0, 16'h0040, 16'h0000, 16'h7777);

    // Reset during WAIT of a read aborts without an ack.
    @(negedge clk);
    drive(0, 0, 16'h0010, 16'h0000);
    push(cyc, 0, 0, 16'h0010, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_mem_en", 32'(mem_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ack", {30'd0, cpu_ack, ldr_ack}, 0);
    chk("abort_cpu_rdata", 32'(cpu_rdata), 0);
    cpu_req = 1'b0;

    // Both requesters held high out of reset: strict alternation, CPU first.
    drive(0, 1, 16'h0050, 16'hC001);
    drive(1, 1, 16'h0060, 16'hD001);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    push(c0,     0, 1, 16'h0050, 16'hC001, 16'h0000, 1'b1);
    push(c0 + 3, 1, 1, 16'h0060, 16'hD001, 16'h0000, 1'b1);
    push(c0 + 6, 0, 1, 16'h0051, 16'hC002, 16'h0000, 1'b1);
    push(c0 + 9, 1, 1, 16'h0061, 16'hD002, 16'h0000, 1'b1);
    fork
      begin
        wait_ack(0, "rr_cpu_ack1");
        cpu_addr = 16'h0051; cpu_wdata = 16'hC002;
        wait_ack(0, "rr_cpu_ack2");
        cpu_req = 1'b0;
      end
      begin
        wait_ack(1, "rr_ldr_ack1");
        ldr_addr = 16'h0061; ldr_wdata = 16'hD002;
        wait_ack(1, "rr_ldr_ack2");
        ldr_req = 1'b0;
      end
    join

    repeat (8) @(negedge clk);
    chk("mem_q_empty", 32'(mem_q.size()), 0);
    chk("cpu_q_empty", 32'(cpu_q.size()), 0);
    chk("ldr_q_empty", 32'(ldr_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
